// File: rtl/cpu_0_ocimem_pkg.sv
// Shared types and jdo field positions for the OCIMEM debug responder.
// CPU_0_OCIMEM_PARITY_EN widens the debug RAM to carry an even-parity bit.
package cpu_0_ocimem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RD_ISSUE = 2'd1,
        ST_RD_CAPT  = 2'd2,
        ST_WR_DO    = 2'd3
    } ocimem_state_e;

    localparam int JDO_ADDR_LSB  = 18;
    localparam int JDO_RDEN_BIT  = 17;
    localparam int JDO_WDATA_LSB = 3;

`ifdef CPU_0_OCIMEM_PARITY_EN
    localparam int RAM_W = 33;

    // Bit that makes the total count of ones in {parity, data} even.
    function automatic logic even_parity(input logic [31:0] data);
        return ^data;
    endfunction
`else
    localparam int RAM_W = 32;
`endif

endpackage

// File: rtl/cpu_0_ocimem_ram.sv
// Single-port synchronous debug RAM with registered read (read-first on write).
// Contents are deliberately not reset.
module cpu_0_ocimem_ram #(
    parameter int AW = 8,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic [AW-1:0] addr,
    input  logic          we,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem_reg [2**AW];
    logic [DW-1:0] rdata_reg;

    always_ff @(posedge clk) begin
        if (we) begin
            mem_reg[addr] <= wdata;
        end
        rdata_reg <= mem_reg[addr];
    end

    assign rdata = rdata_reg;

endmodule

// File: rtl/cpu_0_ocimem_responder.sv
// JTAG OCIMEM command responder plus low-priority CPU port into the debug RAM.
// Optional CPU_0_OCIMEM_PARITY_EN adds parity storage and a JTAG-side parity check.
module cpu_0_ocimem_responder
    import cpu_0_ocimem_pkg::*;
#(
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          debugack,
    input  logic [37:0]   jdo,
    input  logic          take_action_ocimem_a,
    input  logic          take_no_action_ocimem_a,
    input  logic          take_action_ocimem_b,
    input  logic [AW-1:0] cpu_addr,
    input  logic          cpu_read,
    input  logic          cpu_write,
    input  logic [31:0]   cpu_writedata,
    output logic [31:0]   cpu_readdata,
    output logic          cpu_waitrequest,
    output logic [AW-1:0] MonAReg,
    output logic [31:0]   MonDReg,
    output logic          monitor_ready,
    output logic          monitor_error
);

    localparam logic [AW-1:0] ADDR_ONE = {{(AW-1){1'b0}}, 1'b1};

    ocimem_state_e state_reg;
    logic [AW-1:0] mon_a_reg;
    logic [31:0]   mon_d_reg;
    logic          ready_reg;
    logic          ready_pend_reg;
    logic          error_reg;
    logic [31:0]   wdata_reg;
    logic          cpu_rd_pend_reg;
    logic [31:0]   cpu_hold_reg;

    logic             any_strobe;
    logic             multi_strobe;
    logic             jtag_owns;
    logic             cpu_rd_accept;
    logic             cpu_wr_accept;
    logic [AW-1:0]    ram_addr;
    logic             ram_we;
    logic [RAM_W-1:0] ram_wdata;
    logic [RAM_W-1:0] ram_rdata;
    logic [RAM_W-1:0] cpu_wword;
    logic [RAM_W-1:0] jtag_wword;
    logic             rd_parity_err;
    logic             jdo_unused;

    assign jdo_unused = ^{jdo[37:35], jdo[2:0]};

    assign any_strobe   = take_action_ocimem_a | take_no_action_ocimem_a | take_action_ocimem_b;
    assign multi_strobe = (take_action_ocimem_a & (take_no_action_ocimem_a | take_action_ocimem_b))
                        | (take_no_action_ocimem_a & take_action_ocimem_b);

    // The JTAG side has absolute priority on the single RAM port in these two states.
    assign jtag_owns       = (state_reg == ST_RD_ISSUE) || (state_reg == ST_WR_DO);
    assign cpu_waitrequest = (cpu_read | cpu_write) & (jtag_owns | cpu_rd_pend_reg);
    assign cpu_rd_accept   = cpu_read  & ~cpu_waitrequest;
    assign cpu_wr_accept   = cpu_write & ~cpu_waitrequest;

`ifdef CPU_0_OCIMEM_PARITY_EN
    assign cpu_wword     = {even_parity(cpu_writedata), cpu_writedata};
    assign jtag_wword    = {even_parity(wdata_reg), wdata_reg};
    assign rd_parity_err = ^ram_rdata;
`else
    assign cpu_wword     = cpu_writedata;
    assign jtag_wword    = wdata_reg;
    assign rd_parity_err = 1'b0;
`endif

    always_comb begin
        ram_addr  = cpu_addr;
        ram_we    = cpu_wr_accept;
        ram_wdata = cpu_wword;
        if (jtag_owns) begin
            ram_addr  = mon_a_reg;
            ram_we    = (state_reg == ST_WR_DO);
            ram_wdata = jtag_wword;
        end
    end

    cpu_0_ocimem_ram #(
        .AW (AW),
        .DW (RAM_W)
    ) u_ram (
        .clk   (clk),
        .addr  (ram_addr),
        .we    (ram_we),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg      <= ST_IDLE;
            mon_a_reg      <= '0;
            mon_d_reg      <= '0;
            ready_reg      <= 1'b1;
            ready_pend_reg <= 1'b0;
            error_reg      <= 1'b0;
            wdata_reg      <= '0;
        end else begin
            // An address-only load completes one cycle after it is accepted.
            if (ready_pend_reg) begin
                ready_reg      <= 1'b1;
                ready_pend_reg <= 1'b0;
            end

            case (state_reg)
                ST_IDLE: begin
                    if (any_strobe) begin
                        if (!debugack) begin
                            error_reg <= 1'b1;
                            ready_reg <= 1'b1;
                        end else if (take_action_ocimem_a) begin
                            mon_a_reg      <= jdo[JDO_ADDR_LSB +: AW];
                            error_reg      <= multi_strobe;
                            ready_reg      <= 1'b0;
                            ready_pend_reg <= ~jdo[JDO_RDEN_BIT];
                            if (jdo[JDO_RDEN_BIT]) begin
                                state_reg <= ST_RD_ISSUE;
                            end
                        end else if (take_action_ocimem_b) begin
                            wdata_reg      <= jdo[JDO_WDATA_LSB +: 32];
                            ready_reg      <= 1'b0;
                            ready_pend_reg <= 1'b0;
                            state_reg      <= ST_WR_DO;
                            if (multi_strobe) begin
                                error_reg <= 1'b1;
                            end
                        end else begin
                            ready_reg      <= 1'b0;
                            ready_pend_reg <= 1'b0;
                            state_reg      <= ST_RD_ISSUE;
                        end
                    end
                end
                ST_RD_ISSUE: begin
                    state_reg <= ST_RD_CAPT;
                end
                ST_RD_CAPT: begin
                    mon_d_reg <= ram_rdata[31:0];
                    mon_a_reg <= mon_a_reg + ADDR_ONE;
                    ready_reg <= 1'b1;
                    state_reg <= ST_IDLE;
                    if (rd_parity_err) begin
                        error_reg <= 1'b1;
                    end
                end
                ST_WR_DO: begin
                    mon_a_reg <= mon_a_reg + ADDR_ONE;
                    ready_reg <= 1'b1;
                    state_reg <= ST_IDLE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase

            if (any_strobe && (state_reg != ST_IDLE)) begin
                error_reg <= 1'b1;
            end
        end
    end

    // CPU reads return straight from the RAM output register on the cycle after
    // acceptance; the hold register keeps the value stable afterwards.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cpu_rd_pend_reg <= 1'b0;
            cpu_hold_reg    <= '0;
        end else begin
            cpu_rd_pend_reg <= cpu_rd_accept;
            if (cpu_rd_pend_reg) begin
                cpu_hold_reg <= ram_rdata[31:0];
            end
        end
    end

    assign cpu_readdata  = cpu_rd_pend_reg ? ram_rdata[31:0] : cpu_hold_reg;
    assign MonAReg       = mon_a_reg;
    assign MonDReg       = mon_d_reg;
    assign monitor_ready = ready_reg;
    assign monitor_error = error_reg;

endmodule

// File: tb/tb_cpu_0_ocimem_responder.sv
// Scoreboard bench for cpu_0_ocimem_responder: stimulus queues expected JTAG
// completions and CPU read data, a negedge monitor pops and compares them.
module tb_cpu_0_ocimem_responder;

    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          debugack = 1'b0;
    logic [37:0]   jdo = '0;
    logic          take_action_ocimem_a = 1'b0;
    logic          take_no_action_ocimem_a = 1'b0;
    logic          take_action_ocimem_b = 1'b0;
    logic [AW-1:0] cpu_addr = '0;
    logic          cpu_read = 1'b0;
    logic          cpu_write = 1'b0;
    logic [31:0]   cpu_writedata = '0;
    logic [31:0]   cpu_readdata;
    logic          cpu_waitrequest;
    logic [AW-1:0] MonAReg;
    logic [31:0]   MonDReg;
    logic          monitor_ready;
    logic          monitor_error;

    cpu_0_ocimem_responder #(.AW(AW)) dut (
        .clk                     (clk),
        .reset_n                 (reset_n),
        .debugack                (debugack),
        .jdo                     (jdo),
        .take_action_ocimem_a    (take_action_ocimem_a),
        .take_no_action_ocimem_a (take_no_action_ocimem_a),
        .take_action_ocimem_b    (take_action_ocimem_b),
        .cpu_addr                (cpu_addr),
        .cpu_read                (cpu_read),
        .cpu_write               (cpu_write),
        .cpu_writedata           (cpu_writedata),
        .cpu_readdata            (cpu_readdata),
        .cpu_waitrequest         (cpu_waitrequest),
        .MonAReg                 (MonAReg),
        .MonDReg                 (MonDReg),
        .monitor_ready           (monitor_ready),
        .monitor_error           (monitor_error)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [31:0]   d;
        logic [AW-1:0] a;
        logic          err;
        int            at;
    } jexp_t;

    jexp_t       jq[$];
    logic [31:0] cq[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic fail_bound(input string name, input int outstanding);
        checks++;
        errors++;
        $display("FAIL %s: %0d still outstanding, expected 0", name, outstanding);
    endtask

    // Monitor: a rising monitor_ready is one JTAG completion; a CPU read
    // accepted in one cycle is compared on the next.
    logic prev_ready = 1'b1;
    logic cpu_pend = 1'b0;
    always @(negedge clk) begin
        if (!reset_n) begin
            prev_ready = 1'b1;
            cpu_pend   = 1'b0;
        end else begin
            if (monitor_ready && !prev_ready) begin
                $display("jtag done  cyc=%0d MonDReg=%08h MonAReg=%02h err=%b",
                         cyc, MonDReg, MonAReg, monitor_error);
                if (jq.size() == 0) begin
                    fail_bound("jtag_unexpected_completion", 1);
                end else begin
                    jexp_t e;
                    e = jq.pop_front();
                    chk("jtag_MonDReg", MonDReg, e.d);
                    chk("jtag_MonAReg", {24'b0, MonAReg}, {24'b0, e.a});
                    chk("jtag_error", {31'b0, monitor_error}, {31'b0, e.err});
                    chk("jtag_latency_cycle", cyc, e.at);
                end
            end
            prev_ready = monitor_ready;
            if (cpu_pend) begin
                $display("cpu read   cyc=%0d data=%08h", cyc, cpu_readdata);
                if (cq.size() == 0) begin
                    fail_bound("cpu_unexpected_read", 1);
                end else begin
                    chk("cpu_readdata", cpu_readdata, cq.pop_front());
                end
            end
            cpu_pend = cpu_read && !cpu_waitrequest;
        end
    end

    // Expected completion cycle relative to a strobe set just after edge cyc.
    task automatic expect_j(input logic [31:0] d, input logic [AW-1:0] a, input logic err, input int lat);
        jexp_t e;
        e.d   = d;
        e.a   = a;
        e.err = err;
        e.at  = cyc + lat;
        jq.push_back(e);
    endtask

    task automatic strobe(input bit a, input bit n, input bit b,
                          input logic [7:0] addr, input logic rden, input logic [31:0] wd);
        jdo = '0;
        if (b) jdo[34:3] = wd;
        if (a) begin
            jdo[25:18] = addr;
            jdo[17]    = rden;
        end
        take_action_ocimem_a    = a;
        take_no_action_ocimem_a = n;
        take_action_ocimem_b    = b;
        @(posedge clk); #1;
        take_action_ocimem_a    = 1'b0;
        take_no_action_ocimem_a = 1'b0;
        take_action_ocimem_b    = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (jq.size() != 0 && n < 20) begin
            @(negedge clk); #1;
            n++;
        end
        if (jq.size() != 0) begin
            fail_bound("jtag_timeout", jq.size());
            jq.delete();
        end
        @(posedge clk); #1;
    endtask

    task automatic cpu_wr(input logic [AW-1:0] a, input logic [31:0] d);
        int n = 0;
        cpu_addr      = a;
        cpu_writedata = d;
        cpu_write     = 1'b1;
        @(negedge clk);
        while (cpu_waitrequest && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (cpu_waitrequest) fail_bound("cpu_write_stall", 1);
        $display("cpu write  cyc=%0d addr=%02h data=%08h", cyc, a, d);
        @(posedge clk); #1;
        cpu_write = 1'b0;
    endtask

    task automatic cpu_rd(input logic [AW-1:0] a, input logic [31:0] exp);
        int n = 0;
        cpu_addr = a;
        cpu_read = 1'b1;
        @(negedge clk);
        while (cpu_waitrequest && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (cpu_waitrequest) fail_bound("cpu_read_stall", 1);
        else cq.push_back(exp);
        @(posedge clk); #1;
        cpu_read = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_MonAReg", {24'b0, MonAReg}, 32'h0);
        chk("reset_MonDReg", MonDReg, 32'h0);
        chk("reset_ready", {31'b0, monitor_ready}, 32'h1);
        chk("reset_error", {31'b0, monitor_error}, 32'h0);
        chk("reset_cpu_readdata", cpu_readdata, 32'h0);
        chk("reset_waitrequest", {31'b0, cpu_waitrequest}, 32'h0);
        @(negedge clk) reset_n = 1'b1;
        @(posedge clk); #1;
        debugack = 1'b1;

        // Load-and-read
        cpu_wr(8'h10, 32'hDEADBEEF);
        expect_j(32'hDEADBEEF, 8'h11, 1'b0, 3);
        strobe(1, 0, 0, 8'h10, 1'b1, 32'h0);
        wait_done();

        // Burst write wrapping past the top of the RAM
        expect_j(32'hDEADBEEF, 8'hFF, 1'b0, 2);
        strobe(1, 0, 0, 8'hFF, 1'b0, 32'h0);
        wait_done();
        expect_j(32'hDEADBEEF, 8'h00, 1'b0, 2);
        strobe(0, 0, 1, 8'h00, 1'b0, 32'h1);
        wait_done();
        expect_j(32'hDEADBEEF, 8'h01, 1'b0, 2);
        strobe(0, 0, 1, 8'h00, 1'b0, 32'h2);
        wait_done();
        expect_j(32'hDEADBEEF, 8'h02, 1'b0, 2);
        strobe(0, 0, 1, 8'h00, 1'b0, 32'h3);
        wait_done();

        expect_j(32'h1, 8'h00, 1'b0, 3);
        strobe(1, 0, 0, 8'hFF, 1'b1, 32'h0);
        wait_done();
        expect_j(32'h2, 8'h01, 1'b0, 3);
        strobe(0, 1, 0, 8'h00, 1'b0, 32'h0);
        wait_done();
        expect_j(32'h3, 8'h02, 1'b0, 3);
        strobe(0, 1, 0, 8'h00, 1'b0, 32'h0);
        wait_done();
        cpu_rd(8'hFF, 32'h1);
        cpu_rd(8'h00, 32'h2);
        cpu_rd(8'h01, 32'h3);

        // Busy strobe and sticky error
        cpu_wr(8'h20, 32'hCAFEF00D);
        cpu_wr(8'h21, 32'h12345678);
        cpu_wr(8'h22, 32'h11112222);
        expect_j(32'hCAFEF00D, 8'h21, 1'b1, 3);
        strobe(1, 0, 0, 8'h20, 1'b1, 32'h0);
        strobe(0, 0, 1, 8'h00, 1'b0, 32'h55);
        wait_done();
        expect_j(32'h12345678, 8'h22, 1'b1, 3);
        strobe(0, 1, 0, 8'h00, 1'b0, 32'h0);
        wait_done();
        expect_j(32'h12345678, 8'h22, 1'b0, 3);
        strobe(1, 0, 0, 8'h21, 1'b1, 32'h0);
        wait_done();

        // Simultaneous a+b: a wins, b dropped with an error
        expect_j(32'h12345678, 8'h30, 1'b1, 2);
        strobe(1, 0, 1, 8'h30, 1'b0, 32'h99);
        wait_done();
        expect_j(32'h12345678, 8'h22, 1'b0, 2);
        strobe(1, 0, 0, 8'h22, 1'b0, 32'h0);
        wait_done();

        // Strobe outside debug mode
        debugack = 1'b0;
        strobe(0, 0, 1, 8'h00, 1'b0, 32'h00000BAD);
        repeat (2) @(posedge clk);
        #1;
        chk("nodebug_error", {31'b0, monitor_error}, 32'h1);
        chk("nodebug_ready", {31'b0, monitor_ready}, 32'h1);
        chk("nodebug_MonAReg", {24'b0, MonAReg}, 32'h22);
        debugack = 1'b1;
        cpu_rd(8'h22, 32'h11112222);

        // CPU read held across a JTAG write
        expect_j(32'h12345678, 8'h40, 1'b0, 2);
        strobe(1, 0, 0, 8'h40, 1'b0, 32'h0);
        wait_done();
        cpu_wr(8'h50, 32'hA5A5A5A5);
        expect_j(32'h12345678, 8'h41, 1'b0, 2);
        strobe(0, 0, 1, 8'h00, 1'b0, 32'h77);
        cpu_addr = 8'h50;
        cpu_read = 1'b1;
        @(negedge clk);
        chk("arb_wait_in_wr_do", {31'b0, cpu_waitrequest}, 32'h1);
        @(negedge clk);
        chk("arb_accept_after", {31'b0, cpu_waitrequest}, 32'h0);
        cq.push_back(32'hA5A5A5A5);
        @(posedge clk); #1;
        cpu_read = 1'b0;
        wait_done();
        cpu_rd(8'h40, 32'h77);

        // Reset during RD_ISSUE
        cpu_wr(8'h60, 32'h600D600D);
        strobe(1, 0, 0, 8'h60, 1'b1, 32'h0);
        reset_n = 1'b0;
        #1;
        chk("rst_mid_MonDReg", MonDReg, 32'h0);
        chk("rst_mid_ready", {31'b0, monitor_ready}, 32'h1);
        chk("rst_mid_MonAReg", {24'b0, MonAReg}, 32'h0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        chk("rst_after_MonDReg", MonDReg, 32'h0);
        chk("rst_after_ready", {31'b0, monitor_ready}, 32'h1);

`ifdef CPU_0_OCIMEM_PARITY_EN
        cpu_wr(8'h05, 32'h000000F0);
        dut.u_ram.mem_reg[5][32] = ~dut.u_ram.mem_reg[5][32];
        expect_j(32'h000000F0, 8'h06, 1'b1, 3);
        strobe(1, 0, 0, 8'h05, 1'b1, 32'h0);
        wait_done();
`endif

        repeat (3) @(posedge clk);
        #1;
        chk("jtag_queue_drained", jq.size(), 32'h0);
        chk("cpu_queue_drained", cq.size(), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
